// File: rtl/ram_sync.sv
// rtl/ram_sync.sv - byte-addressable big-endian synchronous memory with enable/mfc handshake
// Byte/half/word accesses take one 32-bit beat, doublewords take two, each LATENCY cycles long.
module ram_sync #(
    parameter int ADDR_W      = 9,
    parameter int LATENCY     = 2,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              read_write,
    input  logic [1:0]        data_length,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       data_in,
    output logic [31:0]       data_out,
    output logic              beat_valid,
    output logic              mfc,
    output logic              misaligned,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    state_t            state_q, state_d;
    logic              rw_q, rw_d;
    logic [1:0]        len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              beat_q, beat_d;
    logic [31:0]       dout_q, dout_d;
    logic              bv_q, bv_d;
    logic              mis_q, mis_d;

    logic [7:0]        mem [DEPTH];

    logic              req_misaligned;
    logic              beat_done;
    logic              last_beat;
    logic [ADDR_W-1:0] a0, a1, a2, a3;
    logic [31:0]       rd_data;
    logic              wr_en;
    logic [7:0]        wb0, wb1;

    assign req_misaligned = CHECK_ALIGN &&
                            (((data_length == 2'd1) && address[0]) ||
                             (data_length[1] && (address[1:0] != 2'b00)));

    // cnt_q counts edges since the beat started; the beat lands on the LATENCY-th edge
    assign beat_done = (state_q == S_ACCESS) && (cnt_q == CNT_W'(LATENCY));
    assign last_beat = (beat_q == (len_q == 2'd3));

    assign a0 = addr_q + ADDR_W'({beat_q, 2'b00});
    assign a1 = a0 + ADDR_W'(1);
    assign a2 = a0 + ADDR_W'(2);
    assign a3 = a0 + ADDR_W'(3);

    always_comb begin
        rd_data = {mem[a0], mem[a1], mem[a2], mem[a3]};
        case (len_q)
            2'd0:    rd_data = {24'b0, mem[a0]};
            2'd1:    rd_data = {16'b0, mem[a0], mem[a1]};
            default: rd_data = {mem[a0], mem[a1], mem[a2], mem[a3]};
        endcase
    end

    // Narrow writes take the low-order bytes of data_in, high byte at the lowest address
    assign wr_en = beat_done && !rw_q;
    assign wb0   = (len_q == 2'd0) ? data_in[7:0] :
                   (len_q == 2'd1) ? data_in[15:8] : data_in[31:24];
    assign wb1   = (len_q == 2'd1) ? data_in[7:0] : data_in[23:16];

    always_ff @(posedge clk) begin
        if (!reset && wr_en) begin
            mem[a0] <= wb0;
            if (len_q != 2'd0) begin
                mem[a1] <= wb1;
            end
            if (len_q[1]) begin
                mem[a2] <= data_in[15:8];
                mem[a3] <= data_in[7:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            rw_q    <= 1'b0;
            len_q   <= 2'd0;
            addr_q  <= '0;
            cnt_q   <= '0;
            beat_q  <= 1'b0;
            dout_q  <= 32'd0;
            bv_q    <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rw_q    <= rw_d;
            len_q   <= len_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            dout_q  <= dout_d;
            bv_q    <= bv_d;
            mis_q   <= mis_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = req_misaligned ? S_DONE : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (beat_done && last_beat) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rw_d   = rw_q;
        len_d  = len_q;
        addr_d = addr_q;
        cnt_d  = cnt_q;
        beat_d = beat_q;
        dout_d = dout_q;
        bv_d   = 1'b0;
        mis_d  = mis_q;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    rw_d   = read_write;
                    len_d  = data_length;
                    addr_d = address;
                    cnt_d  = CNT_W'(1);
                    beat_d = 1'b0;
                    mis_d  = req_misaligned;
                end
            end
            S_ACCESS: begin
                if (beat_done) begin
                    bv_d   = 1'b1;
                    cnt_d  = CNT_W'(1);
                    beat_d = 1'b1;
                    if (rw_q) begin
                        dout_d = rd_data;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (!enable) begin
                    mis_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        data_out   = dout_q;
        beat_valid = bv_q;
        mfc        = (state_q == S_DONE);
        misaligned = mis_q;
        busy       = (state_q != S_IDLE);
    end

endmodule

// File: tb/tb_ram_sync.sv
// tb/tb_ram_sync.sv - self-checking bench for ram_sync
// A timeline model predicts every output each cycle; directed transfers add literal checks.
module tb_ram_sync;

    localparam int L = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        en0, en1;
    logic        rw_i;
    logic [1:0]  len_i;
    logic [8:0]  addr_i;
    logic [31:0] din;
    logic [31:0] dout0, dout1;
    logic        bv0, bv1, mfc0, mfc1, mis0, mis1, busy0, busy1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ram_sync #(.ADDR_W(9), .LATENCY(L), .CHECK_ALIGN(1'b1)) dut (
        .clk(clk), .reset(reset), .enable(en0), .read_write(rw_i),
        .data_length(len_i), .address(addr_i), .data_in(din),
        .data_out(dout0), .beat_valid(bv0), .mfc(mfc0),
        .misaligned(mis0), .busy(busy0)
    );

    ram_sync #(.ADDR_W(9), .LATENCY(L), .CHECK_ALIGN(1'b0)) dut_wrap (
        .clk(clk), .reset(reset), .enable(en1), .read_write(rw_i),
        .data_length(len_i), .address(addr_i), .data_in(din),
        .data_out(dout1), .beat_valid(bv1), .mfc(mfc1),
        .misaligned(mis1), .busy(busy1)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (dut only) ----------------
    logic [7:0]  mm [512];
    bit          m_on = 1'b0;
    bit          m_act = 1'b0;
    bit          m_rej;
    logic        m_rw;
    logic [1:0]  m_len;
    int          m_addr;
    int          m_t0;
    int          m_cyc = 0;
    logic [31:0] e_dout = 32'd0;
    bit          e_bv, e_mfc, e_mis, e_busy;

    function automatic int nbytes(input logic [1:0] len);
        return (len == 2'd3) ? 4 : (1 << len);
    endfunction

    function automatic logic [31:0] m_read(input int b, input logic [1:0] len);
        logic [31:0] v = 32'd0;
        for (int i = 0; i < nbytes(len); i++) v = {v[23:0], mm[(b + i) % 512]};
        return v;
    endfunction

    task automatic m_write(input int b, input logic [1:0] len, input logic [31:0] w);
        int n = nbytes(len);
        for (int i = 0; i < n; i++) mm[(b + i) % 512] = 8'((w >> (8 * (n - 1 - i))) & 32'hFF);
    endtask

    function automatic int done_offset(input bit rej, input logic [1:0] len);
        return rej ? 0 : ((len == 2'd3) ? 2 : 1) * L;
    endfunction

    always @(posedge clk) begin
        int rel;
        int nb;
        m_cyc++;
        e_bv = 1'b0;
        if (reset) begin
            m_on   = 1'b1;
            m_act  = 1'b0;
            e_dout = 32'd0;
        end else if (m_act) begin
            rel = m_cyc - m_t0;
            nb  = (m_len == 2'd3) ? 2 : 1;
            if (!m_rej && (rel % L == 0) && (rel / L >= 1) && (rel / L <= nb)) begin
                if (m_rw) e_dout = m_read(m_addr + 4 * (rel / L - 1), m_len);
                else      m_write(m_addr + 4 * (rel / L - 1), m_len, din);
                e_bv = 1'b1;
            end else if (rel > done_offset(m_rej, m_len) && !en0) begin
                m_act = 1'b0;
            end
        end else if (en0) begin
            m_act  = 1'b1;
            m_t0   = m_cyc;
            m_rw   = rw_i;
            m_len  = len_i;
            m_addr = int'(addr_i);
            m_rej  = (m_addr % ((len_i == 2'd3) ? 4 : (1 << len_i))) != 0;
        end
        e_busy = m_act;
        e_mfc  = m_act && ((m_cyc - m_t0) >= done_offset(m_rej, m_len));
        e_mis  = e_mfc && m_rej;
    end

    always @(negedge clk) begin
        if (m_on) begin
            check32("cyc_data_out", dout0, e_dout);
            check_int("cyc_beat_valid", int'(bv0), int'(e_bv));
            check_int("cyc_mfc", int'(mfc0), int'(e_mfc));
            check_int("cyc_misaligned", int'(mis0), int'(e_mis));
            check_int("cyc_busy", int'(busy0), int'(e_busy));
        end
    end

    // ---------------- driver ----------------
    task automatic xfer(input bit use1, input logic rw, input logic [1:0] len, input logic [8:0] a,
                        input logic [31:0] w0, input logic [31:0] w1, input int hold, input bit drop,
                        output logic [31:0] d0, output logic [31:0] d1, output int lat,
                        output int nb, output logic mis, output int hc);
        bit got = 1'b0;
        d0 = 32'd0; d1 = 32'd0; lat = -1; nb = 0; mis = 1'b0; hc = 0;
        rw_i = rw; len_i = len; addr_i = a; din = w0;
        if (use1) en1 = 1'b1; else en0 = 1'b1;
        for (int c = 0; c < 64 && !got; c++) begin
            @(negedge clk);
            if (drop && c == 0) begin
                en0 = 1'b0; en1 = 1'b0;
            end
            if (use1 ? bv1 : bv0) begin
                if (nb == 0) d0 = use1 ? dout1 : dout0;
                else         d1 = use1 ? dout1 : dout0;
                nb++;
                if (!rw && len == 2'd3) din = w1;
            end
            if (use1 ? mfc1 : mfc0) begin
                got = 1'b1;
                lat = c;
                mis = use1 ? mis1 : mis0;
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL xfer_timeout: no mfc within 64 cycles at %0t", $time);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (use1 ? mfc1 : mfc0) hc++;
        end
        en0 = 1'b0; en1 = 1'b0;
        @(negedge clk);
    endtask

    logic [31:0] d0, d1;
    int          lat, nb, hc;
    logic        mis;
    logic [8:0]  wrap_addr [4];
    logic [31:0] wrap_byte [4];

    initial begin
        reset = 1'b1; en0 = 1'b0; en1 = 1'b0;
        rw_i = 1'b1; len_i = 2'd0; addr_i = 9'd0; din = 32'd0;
        wrap_addr[0] = 9'h1FE; wrap_byte[0] = 32'hA1;
        wrap_addr[1] = 9'h1FF; wrap_byte[1] = 32'hB2;
        wrap_addr[2] = 9'h000; wrap_byte[2] = 32'hC3;
        wrap_addr[3] = 9'h001; wrap_byte[3] = 32'hD4;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check32("rst_data_out", dout0, 32'd0);
        check_int("rst_mfc_busy", int'({mfc0, busy0, bv0, mis0}), 0);
        check_int("rst_wrap_outputs", int'({mfc1, busy1, bv1, mis1}), 0);

        // word write, then narrow reads
        xfer(0, 1'b0, 2'd2, 9'h010, 32'hDEADBEEF, 32'd0, 0, 0, d0, d1, lat, nb, mis, hc);
        check_int("word_wr_mfc_offset", lat, L);
        xfer(0, 1'b1, 2'd0, 9'h012, 32'd0, 32'd0, 0, 0, d0, d1, lat, nb, mis, hc);
        check32("byte_rd_012", d0, 32'h000000BE);
        check_int("byte_rd_mfc_offset", lat, L);
        xfer(0, 1'b1, 2'd1, 9'h010, 32'd0, 32'd0, 0, 0, d0, d1, lat, nb, mis, hc);
        check32("half_rd_010", d0, 32'h0000DEAD);

        // doubleword write and read
        xfer(0, 1'b0, 2'd3, 9'h020, 32'h11223344, 32'h55667788, 0, 0, d0, d1, lat, nb, mis, hc);
        check_int("dw_wr_beats", nb, 2);
        check_int("dw_wr_mfc_offset", lat, 2 * L);
        xfer(0, 1'b1, 2'd3, 9'h020, 32'd0, 32'd0, 0, 0, d0, d1, lat, nb, mis, hc);
        check32("dw_rd_beat0", d0, 32'h11223344);
        check32("dw_rd_beat1", d1, 32'h55667788);
        check_int("dw_rd_beats", nb, 2);

        // misaligned rejections
        xfer(0, 1'b1, 2'd2, 9'h013, 32'd0, 32'd0, 0, 0, d0, d1, lat, nb, mis, hc);
        check_int("mis_word_flag", int'(mis), 1);
        check_int("mis_word_mfc_offset", lat, 0);
        check_int("mis_word_beats", nb, 0);
        check32("mis_word_dout_kept", dout0, 32'h55667788);
        xfer(0, 1'b0, 2'd2, 9'h011, 32'hFFFFFFFF, 32'd0, 0, 0, d0, d1, lat, nb, mis, hc);
        check_int("mis_word_wr_flag", int'(mis), 1);
        xfer(0, 1'b1, 2'd1, 9'h011, 32'd0, 32'd0, 0, 0, d0, d1, lat, nb, mis, hc);
        check_int("mis_half_flag", int'(mis), 1);
        xfer(0, 1'b1, 2'd2, 9'h010, 32'd0, 32'd0, 0, 0, d0, d1, lat, nb, mis, hc);
        check32("mem_unchanged_010", d0, 32'hDEADBEEF);
        check_int("aligned_flag_clear", int'(mis), 0);

        // byte write merges into an existing word
        xfer(0, 1'b0, 2'd0, 9'h013, 32'h0000005A, 32'd0, 0, 0, d0, d1, lat, nb, mis, hc);
        xfer(0, 1'b1, 2'd2, 9'h010, 32'd0, 32'd0, 0, 0, d0, d1, lat, nb, mis, hc);
        check32("byte_wr_merge", d0, 32'hDEADBE5A);

        // address wrap on the unchecked instance
        xfer(1, 1'b0, 2'd2, 9'h1FE, 32'hA1B2C3D4, 32'd0, 0, 0, d0, d1, lat, nb, mis, hc);
        check_int("wrap_wr_not_rejected", int'(mis), 0);
        for (int i = 0; i < 4; i++) begin
            xfer(1, 1'b1, 2'd0, wrap_addr[i], 32'd0, 32'd0, 0, 0, d0, d1, lat, nb, mis, hc);
            check32("wrap_byte", d0, wrap_byte[i]);
        end
        xfer(1, 1'b1, 2'd2, 9'h1FE, 32'd0, 32'd0, 0, 0, d0, d1, lat, nb, mis, hc);
        check32("wrap_word", d0, 32'hA1B2C3D4);

        // handshake: enable held in DONE, then enable dropped during ACCESS
        xfer(0, 1'b0, 2'd2, 9'h030, 32'h0BADCAFE, 32'd0, 5, 0, d0, d1, lat, nb, mis, hc);
        check_int("hold_mfc_cycles", hc, 5);
        check_int("hold_single_beat", nb, 1);
        xfer(0, 1'b0, 2'd2, 9'h034, 32'h12345678, 32'd0, 0, 1, d0, d1, lat, nb, mis, hc);
        check_int("drop_mfc_gone", int'(mfc0), 0);
        xfer(0, 1'b1, 2'd2, 9'h034, 32'd0, 32'd0, 0, 0, d0, d1, lat, nb, mis, hc);
        check32("drop_write_committed", d0, 32'h12345678);

        // reset in the middle of a doubleword write
        rw_i = 1'b0; len_i = 2'd3; addr_i = 9'h040; din = 32'hCAFEF00D; en0 = 1'b1;
        begin
            bit seen = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                @(negedge clk);
                if (bv0) seen = 1'b1;
            end
            check_int("rst_dw_beat0_seen", int'(seen), 1);
        end
        din = 32'h0F0F0F0F;
        @(negedge clk);
        reset = 1'b1; en0 = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check32("midrst_data_out", dout0, 32'd0);
        check_int("midrst_mfc", int'(mfc0), 0);
        check_int("midrst_busy", int'(busy0), 0);
        xfer(0, 1'b1, 2'd2, 9'h040, 32'd0, 32'd0, 0, 0, d0, d1, lat, nb, mis, hc);
        check32("midrst_beat0_kept", d0, 32'hCAFEF00D);
        check_int("midrst_next_mfc_offset", lat, L);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
